cpu_control_unit: RTL and testbench

- Sequencer that drives the shared-bus datapath.
- Fetches 23-bit instruction words from a synchronous-read program ROM.
- Decodes each word and issues one-hot register-load enables (r_en_OH) and tri-state bus-driver selects (tri_controller_OH), one bus transfer per cycle.
- Presents the latched instruction on code so the datapath sees the ALU op on code[22:20] and immediates on code[15:0].

---
 rtl/cpu_control_unit.sv | 146 ++++++++++++++
 tb/tb_cpu_control_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_unit.sv
// Purpose : shared-bus sequencer; fetches from a sync-read ROM, decodes, issues one-hot load/drive selects.
// Latency : MOV 3 cycles, ALU 5, LDI 5, HALT 2; enables are Moore outputs of state/dst/src.
// Backpressure: none; the datapath absorbs one bus transfer per cycle, run is sampled only in IDLE.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   run                start request, honoured only in IDLE
//   instr              ROM read data, valid the cycle after address is presented
//   address            ROM address (always the program counter)
//   code               instruction register; ALU op on [22:20], immediate on [15:0]
//   r_en_OH            one-hot register load enables (R0..R7, G, A)
//   tri_controller_OH  one-hot bus driver selects (R0..R7, G, immediate)
//   busy, halted       status: busy outside IDLE/HALTED, halted in HALTED
module cpu_control_unit #(
   parameter int ADDR_W  = 6,
   parameter int CODE_W  = 23,
   parameter int NUM_GPR = 8,
   parameter int G_IDX   = 9,
   parameter int A_IDX   = 10,
   parameter int IMM_IDX = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic [CODE_W-1:0] instr,
   output logic [ADDR_W-1:0] address,
   output logic [CODE_W-1:0] code,
   output logic [19:0]       r_en_OH,
   output logic [19:0]       tri_controller_OH,
   output logic              busy,
   output logic              halted
);

   localparam int RW = $clog2(NUM_GPR);

   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_FETCH    = 4'd1;
   localparam logic [3:0] S_DECODE   = 4'd2;
   localparam logic [3:0] S_MOV_X    = 4'd3;
   localparam logic [3:0] S_ALU_A    = 4'd4;
   localparam logic [3:0] S_ALU_G    = 4'd5;
   localparam logic [3:0] S_ALU_WB   = 4'd6;
   localparam logic [3:0] S_LDI_ADDR = 4'd7;
   localparam logic [3:0] S_LDI_DATA = 4'd8;
   localparam logic [3:0] S_LDI_WB   = 4'd9;
   localparam logic [3:0] S_HALTED   = 4'd10;

   localparam logic [1:0] C_LDI = 2'b00;
   localparam logic [1:0] C_MOV = 2'b01;
   localparam logic [1:0] C_ALU = 2'b10;

   logic [3:0]        state;
   logic [3:0]        state_nxt;
   logic [ADDR_W-1:0] pc;
   logic [CODE_W-1:0] ir;
   logic [RW-1:0]     dst;
   logic [RW-1:0]     src;

   // FETCH only presents pc; the ROM word is on instr during DECODE,
   // so the class is decoded straight from instr rather than from ir.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:     if (run) state_nxt = S_FETCH;
         S_FETCH:    state_nxt = S_DECODE;
         S_DECODE: begin
            case (instr[19:18])
               C_LDI:   state_nxt = S_LDI_ADDR;
               C_MOV:   state_nxt = S_MOV_X;
               C_ALU:   state_nxt = S_ALU_A;
               default: state_nxt = S_HALTED;
            endcase
         end
         S_MOV_X:    state_nxt = S_FETCH;
         S_ALU_A:    state_nxt = S_ALU_G;
         S_ALU_G:    state_nxt = S_ALU_WB;
         S_ALU_WB:   state_nxt = S_FETCH;
         S_LDI_ADDR: state_nxt = S_LDI_DATA;
         S_LDI_DATA: state_nxt = S_LDI_WB;
         S_LDI_WB:   state_nxt = S_FETCH;
         S_HALTED:   state_nxt = S_HALTED;
         default:    state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         pc    <= '0;
         ir    <= '0;
         dst   <= '0;
         src   <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_DECODE) begin
            ir  <= instr;
            dst <= instr[3 +: RW];
            src <= instr[0 +: RW];
            pc  <= pc + ADDR_W'(1);
         end
         // Second LDI word: only the immediate half of ir is replaced so
         // the first word's alu_op stays visible on code.
         if (state == S_LDI_DATA) begin
            ir[15:0] <= instr[15:0];
            pc       <= pc + ADDR_W'(1);
         end
      end
   end

   always_comb begin
      r_en_OH           = '0;
      tri_controller_OH = '0;
      case (state)
         S_MOV_X: begin
            tri_controller_OH[src] = 1'b1;
            r_en_OH[dst]           = 1'b1;
         end
         S_ALU_A: begin
            tri_controller_OH[dst] = 1'b1;
            r_en_OH[A_IDX]         = 1'b1;
         end
         S_ALU_G: begin
            tri_controller_OH[src] = 1'b1;
            r_en_OH[G_IDX]         = 1'b1;
         end
         S_ALU_WB: begin
            tri_controller_OH[G_IDX] = 1'b1;
            r_en_OH[dst]             = 1'b1;
         end
         S_LDI_WB: begin
            tri_controller_OH[IMM_IDX] = 1'b1;
            r_en_OH[dst]               = 1'b1;
         end
         default: begin
            r_en_OH           = '0;
            tri_controller_OH = '0;
         end
      endcase
   end

   assign address = pc;
   assign code    = ir;
   assign busy    = (state != S_IDLE) && (state != S_HALTED);
   assign halted  = (state == S_HALTED);

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: instruction-level model plus directed literal checks.
module tb_cpu_control_unit;

   localparam logic [22:0] HALT_W = 23'h0C0000;

   logic        clk   = 1'b0;
   logic        rst   = 1'b1;
   logic        run   = 1'b0;
   logic [22:0] instr = '0;
   logic [5:0]  address;
   logic [22:0] code;
   logic [19:0] r_en_OH;
   logic [19:0] tri_controller_OH;
   logic        busy;
   logic        halted;

   logic [22:0] rom [64];

   int total = 0;
   int bad   = 0;

   cpu_control_unit dut (
      .clk               (clk),
      .rst               (rst),
      .run               (run),
      .instr             (instr),
      .address           (address),
      .code              (code),
      .r_en_OH           (r_en_OH),
      .tri_controller_OH (tri_controller_OH),
      .busy              (busy),
      .halted            (halted)
   );

   always #5 clk = ~clk;

   // synchronous-read program ROM
   always @(posedge clk) instr <= rom[address];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic [5:0]  addr;
      logic [22:0] code;
      logic [19:0] ren;
      logic [19:0] tri_s;
      logic        busy;
      logic        halted;
   } exp_t;

   exp_t        q[$];
   exp_t        exp_v;
   int          m_mode = 0;      // 0 idle, 1 running, 2 halted
   logic [5:0]  m_pc   = '0;
   logic [22:0] m_code = '0;
   bit          m_halt_next = 1'b0;
   bit          chk_en = 1'b0;

   function automatic exp_t mk(input logic [5:0] a, input logic [22:0] c,
                               input logic [19:0] ren, input logic [19:0] tr,
                               input logic b, input logic h);
      exp_t e;
      e.addr = a; e.code = c; e.ren = ren; e.tri_s = tr; e.busy = b; e.halted = h;
      return e;
   endfunction

   // Expand the instruction at m_pc into its per-cycle output schedule.
   task automatic build_instr();
      logic [5:0]  p, p1, p2;
      logic [22:0] w, w2, nc;
      logic [2:0]  rx, ry;
      p  = m_pc;
      p1 = p + 6'd1;
      p2 = p + 6'd2;
      w  = rom[p];
      rx = w[5:3];
      ry = w[2:0];
      q.push_back(mk(p, m_code, 20'd0, 20'd0, 1'b1, 1'b0));   // fetch
      q.push_back(mk(p, m_code, 20'd0, 20'd0, 1'b1, 1'b0));   // decode
      case (w[19:18])
         2'b00: begin
            w2 = rom[p1];
            nc = {w[22:16], w2[15:0]};
            q.push_back(mk(p1, w, 20'd0, 20'd0, 1'b1, 1'b0));
            q.push_back(mk(p1, w, 20'd0, 20'd0, 1'b1, 1'b0));
            q.push_back(mk(p2, nc, 20'd1 << rx, 20'd1 << 10, 1'b1, 1'b0));
            m_pc = p2; m_code = nc;
         end
         2'b01: begin
            q.push_back(mk(p1, w, 20'd1 << rx, 20'd1 << ry, 1'b1, 1'b0));
            m_pc = p1; m_code = w;
         end
         2'b10: begin
            q.push_back(mk(p1, w, 20'd1 << 10, 20'd1 << rx, 1'b1, 1'b0));
            q.push_back(mk(p1, w, 20'd1 << 9,  20'd1 << ry, 1'b1, 1'b0));
            q.push_back(mk(p1, w, 20'd1 << rx, 20'd1 << 9,  1'b1, 1'b0));
            m_pc = p1; m_code = w;
         end
         default: begin
            m_pc = p1; m_code = w; m_halt_next = 1'b1;
         end
      endcase
   endtask

   always @(posedge clk) begin
      if (rst) begin
         q.delete();
         m_mode = 0; m_pc = '0; m_code = '0; m_halt_next = 1'b0;
         chk_en = 1'b1;
         exp_v  = mk(6'd0, 23'd0, 20'd0, 20'd0, 1'b0, 1'b0);
      end else begin
         if (m_mode == 0 && run) m_mode = 1;
         if (m_mode == 1 && q.size() == 0) begin
            if (m_halt_next) begin
               m_mode = 2; m_halt_next = 1'b0;
            end else begin
               build_instr();
            end
         end
         if (m_mode == 1) exp_v = q.pop_front();
         else             exp_v = mk(m_pc, m_code, 20'd0, 20'd0, 1'b0, m_mode == 2);
      end
   end

   // compare process
   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_address", 32'(address),           32'(exp_v.addr));
         chk("m_code",    32'(code),              32'(exp_v.code));
         chk("m_r_en",    32'(r_en_OH),           32'(exp_v.ren));
         chk("m_tri",     32'(tri_controller_OH), 32'(exp_v.tri_s));
         chk("m_busy",    32'(busy),              32'(exp_v.busy));
         chk("m_halted",  32'(halted),            32'(exp_v.halted));
         chk("onehot_r_en", 32'($onehot0(r_en_OH)),           32'd1);
         chk("onehot_tri",  32'($onehot0(tri_controller_OH)), 32'd1);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      run = 1'b0;
      @(negedge clk);
      chk("rst_address", 32'(address), 32'd0);
      chk("rst_code",    32'(code), 32'd0);
      chk("rst_r_en",    32'(r_en_OH), 32'd0);
      chk("rst_tri",     32'(tri_controller_OH), 32'd0);
      chk("rst_busy",    32'(busy), 32'd0);
      chk("rst_halted",  32'(halted), 32'd0);
      rst = 1'b0;
   endtask

   // One-cycle run pulse; returns at the negedge of the first FETCH cycle.
   task automatic start();
      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
   endtask

   initial begin
      logic [5:0] iv;
      for (int i = 0; i < 64; i++) rom[i] = HALT_W;
      do_reset();

      // MOV R2,R5 then HALT
      rom[0] = 23'h040015; rom[1] = HALT_W;
      do_reset();
      start();
      chk("mov_busy_c1", 32'(busy), 32'd1);
      chk("mov_addr_c1", 32'(address), 32'd0);
      tick(2);
      chk("mov_tri",  32'(tri_controller_OH), 32'h00020);
      chk("mov_r_en", 32'(r_en_OH), 32'h00004);
      chk("mov_addr", 32'(address), 32'd1);
      tick(1);
      chk("mov_next_addr", 32'(address), 32'd1);
      tick(2);
      chk("mov_halt_halted", 32'(halted), 32'd1);
      chk("mov_halt_addr",   32'(address), 32'd2);

      // LDI R1, 16'hBEEF then HALT
      rom[0] = 23'h000008; rom[1] = 23'h00BEEF; rom[2] = HALT_W;
      do_reset();
      start();
      tick(4);
      chk("ldi_code",  32'(code), 32'h00BEEF);
      chk("ldi_tri",   32'(tri_controller_OH), 32'h00400);
      chk("ldi_r_en",  32'(r_en_OH), 32'h00002);
      tick(1);
      chk("ldi_next_addr", 32'(address), 32'd2);

      // ALU op 3, R4,R6 with junk in ignored bits; run re-raised while busy
      rom[0] = 23'h3AAF26; rom[1] = HALT_W;
      do_reset();
      start();
      run = 1'b1;
      tick(2);
      chk("alu_a_tri",  32'(tri_controller_OH), 32'h00010);
      chk("alu_a_r_en", 32'(r_en_OH), 32'h00400);
      tick(1);
      chk("alu_g_tri",  32'(tri_controller_OH), 32'h00040);
      chk("alu_g_r_en", 32'(r_en_OH), 32'h00200);
      chk("alu_g_op",   32'(code[22:20]), 32'd3);
      tick(1);
      chk("alu_wb_tri",  32'(tri_controller_OH), 32'h00200);
      chk("alu_wb_r_en", 32'(r_en_OH), 32'h00010);
      tick(3);
      chk("alu_halted", 32'(halted), 32'd1);
      run = 1'b0;

      // two MOVs (second is R3,R3) then HALT, run held high afterwards
      rom[0] = 23'h040015; rom[1] = 23'h04001B; rom[2] = HALT_W;
      do_reset();
      start();
      tick(5);
      chk("mov33_tri",  32'(tri_controller_OH), 32'h00008);
      chk("mov33_r_en", 32'(r_en_OH), 32'h00008);
      tick(3);
      chk("halt_halted", 32'(halted), 32'd1);
      chk("halt_busy",   32'(busy), 32'd0);
      chk("halt_addr",   32'(address), 32'd3);
      run = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick(1);
         chk("halt_hold_r_en", 32'(r_en_OH), 32'd0);
         chk("halt_hold_tri",  32'(tri_controller_OH), 32'd0);
         chk("halt_hold_halted", 32'(halted), 32'd1);
      end
      run = 1'b0;

      // reset during ALU_G, then restart from ROM[0]
      rom[0] = 23'h3AAF26; rom[1] = HALT_W;
      do_reset();
      start();
      tick(3);
      chk("mid_alu_g_tri", 32'(tri_controller_OH), 32'h00040);
      do_reset();
      start();
      tick(2);
      chk("restart_tri",  32'(tri_controller_OH), 32'h00010);
      chk("restart_r_en", 32'(r_en_OH), 32'h00400);
      chk("restart_addr", 32'(address), 32'd1);

      // pc wrap: 63 MOVs, LDI R7 at 63, immediate comes from ROM[0]
      rom[0] = 23'h041234;          // MOV R6,R4 whose low half doubles as the immediate
      for (int i = 1; i < 63; i++) begin
         iv = 6'(i);
         rom[i] = {iv[2:0], 2'b01, iv, iv, iv[2:0], iv[5:3]};
      end
      rom[63] = 23'h000038;
      do_reset();
      start();
      tick(193);
      chk("wrap_code",  32'(code), 32'h001234);
      chk("wrap_tri",   32'(tri_controller_OH), 32'h00400);
      chk("wrap_r_en",  32'(r_en_OH), 32'h00080);
      chk("wrap_addr",  32'(address), 32'd1);
      tick(1);
      chk("wrap_fetch_addr", 32'(address), 32'd1);
      chk("wrap_fetch_busy", 32'(busy), 32'd1);
      tick(10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
